// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
//   Round-robin arbiter that moves single words from four source FIFOs into
//   one destination FIFO. Each transfer is a pop of the granted source
//   followed by a push of that word into the destination.
//
//   Optional feature: define ARB_BURST_EN to let a grant keep the datapath
//   for up to four back-to-back words (PUSH -> POP on the same queue).
//
// Ports
//   clk               system clock, rising edge
//   reset             asynchronous reset, active low
//   fifo_empty[3:0]   per-source empty flag
//   fifo_error[3:0]   per-source error flag; masks the source from arbitration
//   data_in_0..3      per-source pop data, valid the cycle after its read
//   dest_almost_full  destination back-pressure, sampled only at arbitration
//   read[3:0]         one-hot pop strobe to the sources
//   dest_write        push strobe to the destination
//   dest_data         pushed word (zero outside PUSH)
//   grant[1:0]        source currently owning the datapath
//   arb_busy          high whenever the FSM is not in IDLE
//   word_count[7:0]   words pushed, wraps at 256
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an eligible source and no back-pressure
// POP   | read strobe asserted to the granted source
// PUSH  | popped word forwarded to the destination, counter bumped

module fifo_rr_arbiter #(
   parameter int DATA_SIZE = 8,
   parameter int NUM_Q     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_Q-1:0]     fifo_empty,
   input  logic [NUM_Q-1:0]     fifo_error,
   input  logic [DATA_SIZE-1:0] data_in_0,
   input  logic [DATA_SIZE-1:0] data_in_1,
   input  logic [DATA_SIZE-1:0] data_in_2,
   input  logic [DATA_SIZE-1:0] data_in_3,
   input  logic                 dest_almost_full,
   output logic [NUM_Q-1:0]     read,
   output logic                 dest_write,
   output logic [DATA_SIZE-1:0] dest_data,
   output logic [1:0]           grant,
   output logic                 arb_busy,
   output logic [7:0]           word_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      PUSH = 2'd2
   } state_t;

   state_t     state;
   logic [1:0] last_grant;

   logic [3:0] eligible;
   logic       any_eligible;
   logic [1:0] scan_start;
   logic [7:0] elig_dbl;
   logic [3:0] elig_rot;
   logic [1:0] rr_offset;
   logic [1:0] rr_pick;

   assign eligible     = ~fifo_empty & ~fifo_error;
   assign any_eligible = |eligible;
   assign scan_start   = last_grant + 2'd1;

   // Rotate the eligibility vector so the scan start sits at bit 0, take
   // the lowest set bit, then rotate the index back.
   always_comb begin
      elig_dbl  = {eligible, eligible};
      elig_rot  = elig_dbl[scan_start +: 4];
      rr_offset = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (elig_rot[k]) rr_offset = 2'(k);
      end
      rr_pick = scan_start + rr_offset;
   end

`ifdef ARB_BURST_EN
   logic [1:0] burst_cnt;
   logic       burst_go;

   // burst_cnt counts extra words already taken on this grant; at 3 the
   // grant has moved four words and must go back to arbitration.
   assign burst_go = eligible[grant] && !dest_almost_full && (burst_cnt != 2'd3);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         read       <= '0;
         dest_write <= 1'b0;
         grant      <= 2'd0;
         last_grant <= 2'd3;
         arb_busy   <= 1'b0;
         word_count <= 8'd0;
`ifdef ARB_BURST_EN
         burst_cnt  <= 2'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!dest_almost_full && any_eligible) begin
                  grant    <= rr_pick;
                  read     <= 4'b0001 << rr_pick;
                  arb_busy <= 1'b1;
                  state    <= POP;
`ifdef ARB_BURST_EN
                  burst_cnt <= 2'd0;
`endif
               end
            end
            POP: begin
               read       <= '0;
               dest_write <= 1'b1;
               state      <= PUSH;
            end
            PUSH: begin
               dest_write <= 1'b0;
               word_count <= word_count + 8'd1;
`ifdef ARB_BURST_EN
               if (burst_go) begin
                  read      <= 4'b0001 << grant;
                  burst_cnt <= burst_cnt + 2'd1;
                  state     <= POP;
               end else begin
                  last_grant <= grant;
                  arb_busy   <= 1'b0;
                  state      <= IDLE;
               end
`else
               last_grant <= grant;
               arb_busy   <= 1'b0;
               state      <= IDLE;
`endif
            end
            default: begin
               read       <= '0;
               dest_write <= 1'b0;
               arb_busy   <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

   // Destination data is a plain mux on the registered grant so the popped
   // word reaches the destination in the same cycle it appears at data_in.
   always_comb begin
      dest_data = '0;
      if (state == PUSH) begin
         case (grant)
            2'd0:    dest_data = data_in_0;
            2'd1:    dest_data = data_in_1;
            2'd2:    dest_data = data_in_2;
            default: dest_data = data_in_3;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter
//   Self-checking bench for fifo_rr_arbiter. Source FIFOs are modelled with
//   queues; the expected behaviour comes from a transfer-timeline model:
//   a transfer granted at edge t shows read at t, write at t+1, frees the
//   arbiter at t+2 and the next arbitration happens at edge t+3.

module tb_fifo_rr_arbiter;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    fifo_empty = 4'hF;
   logic [3:0]    fifo_error;
   logic [DW-1:0] data_in_0, data_in_1, data_in_2, data_in_3;
   logic          dest_almost_full;
   logic [3:0]    read;
   logic          dest_write;
   logic [DW-1:0] dest_data;
   logic [1:0]    grant;
   logic          arb_busy;
   logic [7:0]    word_count;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] src_q [4][$];
   logic [DW-1:0] din [4] = '{default: '0};

   assign data_in_0 = din[0];
   assign data_in_1 = din[1];
   assign data_in_2 = din[2];
   assign data_in_3 = din[3];

   fifo_rr_arbiter #(.DATA_SIZE(DW), .NUM_Q(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .fifo_empty       (fifo_empty),
      .fifo_error       (fifo_error),
      .data_in_0        (data_in_0),
      .data_in_1        (data_in_1),
      .data_in_2        (data_in_2),
      .data_in_3        (data_in_3),
      .dest_almost_full (dest_almost_full),
      .read             (read),
      .dest_write       (dest_write),
      .dest_data        (dest_data),
      .grant            (grant),
      .arb_busy         (arb_busy),
      .word_count       (word_count)
   );

   always #5 clk = ~clk;

   // Source FIFO model: pops on a sampled read, output word registered.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (read[i] && src_q[i].size() > 0) din[i] <= src_q[i].pop_front();
         fifo_empty[i] <= (src_q[i].size() == 0);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_q();
      for (int i = 0; i < 4; i++) src_q[i].delete();
   endtask

   function automatic int pick(input int lst, input logic [3:0] el);
      for (int k = 1; k <= 4; k++) begin
         if (el[(lst + k) % 4]) return (lst + k) % 4;
      end
      return -1;
   endfunction

   function automatic int idx_of(input logic [3:0] oh);
      for (int i = 0; i < 4; i++) if (oh[i]) return i;
      return -1;
   endfunction

   typedef struct {
      logic [3:0] empty;
      logic [3:0] err;
      logic       af;
      logic [3:0] exp_read;
   } vec_t;

   vec_t tbl [10];
   int   got [8];
   int   n;

   initial begin
      tbl[0] = '{4'b1111, 4'b0000, 1'b0, 4'b0000};
      tbl[1] = '{4'b0000, 4'b0000, 1'b0, 4'b0001};
      tbl[2] = '{4'b0101, 4'b0000, 1'b0, 4'b0010};
      tbl[3] = '{4'b0111, 4'b0000, 1'b0, 4'b1000};
      tbl[4] = '{4'b0000, 4'b0001, 1'b0, 4'b0010};
      tbl[5] = '{4'b0000, 4'b1111, 1'b0, 4'b0000};
      tbl[6] = '{4'b0000, 4'b0000, 1'b1, 4'b0000};
      tbl[7] = '{4'b1011, 4'b0000, 1'b0, 4'b0100};
      tbl[8] = '{4'b1001, 4'b0010, 1'b0, 4'b0100};
      tbl[9] = '{4'b0011, 4'b1000, 1'b0, 4'b0100};

      reset = 1'b0;
      fifo_error = 4'b0000;
      dest_almost_full = 1'b0;
      tick();
      tick();

      // reset state
      chk("rst_read",  32'(read), 32'h0);
      chk("rst_write", 32'(dest_write), 32'h0);
      chk("rst_data",  32'(dest_data), 32'h0);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_busy",  32'(arb_busy), 32'h0);
      chk("rst_count", 32'(word_count), 32'h0);

      // first arbitration out of reset for a set of eligibility patterns
      for (int v = 0; v < 10; v++) begin
         reset = 1'b0;
         clear_q();
         for (int i = 0; i < 4; i++) if (!tbl[v].empty[i]) src_q[i].push_back(8'(8'h10 + i));
         fifo_error = tbl[v].err;
         dest_almost_full = tbl[v].af;
         tick();
         reset = 1'b1;
         tick();
         chk($sformatf("tbl%0d_read", v), 32'(read), 32'(tbl[v].exp_read));
         chk($sformatf("tbl%0d_busy", v), 32'(arb_busy), 32'(|tbl[v].exp_read));
      end

`ifndef ARB_BURST_EN
      // queues 1 and 3 non-empty after reset
      reset = 1'b0;
      clear_q();
      fifo_error = 4'b0000;
      dest_almost_full = 1'b0;
      src_q[1].push_back(8'hA1);
      src_q[1].push_back(8'hB1);
      src_q[3].push_back(8'hA3);
      tick();
      reset = 1'b1;
      tick();
      chk("s1_read1",  32'(read), 32'b0010);
      chk("s1_grant1", 32'(grant), 32'd1);
      tick();
      chk("s1_write",  32'(dest_write), 32'h1);
      chk("s1_data",   32'(dest_data), 32'hA1);
      chk("s1_read_off", 32'(read), 32'h0);
      tick();
      chk("s1_idle_write", 32'(dest_write), 32'h0);
      chk("s1_idle_data",  32'(dest_data), 32'h0);
      chk("s1_count",      32'(word_count), 32'd1);
      chk("s1_idle_busy",  32'(arb_busy), 32'h0);
      tick();
      chk("s1_read3",  32'(read), 32'b1000);
      tick();
      chk("s1_data3",  32'(dest_data), 32'hA3);
      tick();
      chk("s1_count2", 32'(word_count), 32'd2);
      tick();
      chk("s1_read1b", 32'(read), 32'b0010);

      // asynchronous reset in the middle of POP
      reset = 1'b0;
      #1;
      chk("rp_read",  32'(read), 32'h0);
      chk("rp_busy",  32'(arb_busy), 32'h0);
      chk("rp_count", 32'(word_count), 32'h0);
      chk("rp_grant", 32'(grant), 32'h0);
      tick();
      chk("rp_nowrite", 32'(dest_write), 32'h0);
      reset = 1'b1;
      tick();
      chk("rp_rearb", 32'(read), 32'b0010);
      tick();
      chk("rp_data",  32'(dest_data), 32'hB1);
      tick();

      // all four queues busy: eight transfers in strict rotation
      reset = 1'b0;
      clear_q();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 3; j++) src_q[i].push_back(8'(8'h40 + 16 * i + j));
      tick();
      reset = 1'b1;
      n = 0;
      for (int c = 0; c < 60 && n < 8; c++) begin
         tick();
         if (read != 4'b0000) begin
            got[n] = idx_of(read);
            n++;
         end
      end
      chk("rr_len", 32'(n), 32'd8);
      for (int k = 0; k < 8; k++) chk($sformatf("rr_grant%0d", k), 32'(got[k]), 32'(k % 4));
      tick();
      tick();
      chk("rr_count", 32'(word_count), 32'd8);

      // destination back-pressure held for ten cycles
      dest_almost_full = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("af_read%0d", c),  32'(read), 32'h0);
         chk($sformatf("af_write%0d", c), 32'(dest_write), 32'h0);
      end
      dest_almost_full = 1'b0;
      tick();
      chk("af_resume", 32'(read), 32'b0001);
      tick();
      tick();

      // queue 2 in error is skipped
      reset = 1'b0;
      clear_q();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 2; j++) src_q[i].push_back(8'(8'h80 + 16 * i + j));
      fifo_error = 4'b0100;
      tick();
      reset = 1'b1;
      n = 0;
      for (int c = 0; c < 40 && n < 5; c++) begin
         tick();
         if (read != 4'b0000) begin
            got[n] = idx_of(read);
            n++;
         end
      end
      chk("err_len", 32'(n), 32'd5);
      chk("err_g0", 32'(got[0]), 32'd0);
      chk("err_g1", 32'(got[1]), 32'd1);
      chk("err_g2", 32'(got[2]), 32'd3);
      chk("err_g3", 32'(got[3]), 32'd0);
      chk("err_g4", 32'(got[4]), 32'd1);

      // randomized traffic against the transfer-timeline model
      begin
         int e, free_edge, wr_edge, last, g_exp, exp_cnt, g;
         logic [3:0]    pre_elig, exp_read;
         logic          pre_af;
         logic [DW-1:0] exp_word;
         reset = 1'b0;
         clear_q();
         fifo_error = 4'b0000;
         dest_almost_full = 1'b0;
         tick();
         reset = 1'b1;
         e = 0; free_edge = 1; wr_edge = -10; last = 3; g_exp = 0; exp_cnt = 0;
         exp_word = '0;
         for (int it = 0; it < 1500; it++) begin
            pre_elig = ~fifo_empty & ~fifo_error;
            pre_af   = dest_almost_full;
            tick();
            e++;
            if (e == wr_edge + 1) exp_cnt = (exp_cnt + 1) % 256;
            exp_read = 4'b0000;
            if (e >= free_edge && !pre_af && pre_elig != 4'b0000) begin
               g = pick(last, pre_elig);
               exp_read = 4'(1 << g);
               g_exp = g;
               last = g;
               wr_edge = e + 1;
               free_edge = e + 3;
               exp_word = src_q[g][0];
            end
            chk("rnd_read",  32'(read), 32'(exp_read));
            chk("rnd_write", 32'(dest_write), 32'(e == wr_edge));
            chk("rnd_data",  32'(dest_data), (e == wr_edge) ? 32'(exp_word) : 32'h0);
            chk("rnd_grant", 32'(grant), 32'(g_exp));
            chk("rnd_busy",  32'(arb_busy), 32'(e <= wr_edge));
            chk("rnd_count", 32'(word_count), 32'(exp_cnt));

            for (int r = 0; r < 2; r++) begin
               int q;
               q = int'($urandom_range(0, 3));
               if (src_q[q].size() < 6) src_q[q].push_back(8'($urandom));
            end
            if ($urandom_range(0, 7) == 0) fifo_error = 4'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 9) == 0) dest_almost_full = ~dest_almost_full;
         end
         chk("rnd_wrapped", 32'(exp_cnt != 0 || e > 0), 32'h1);
      end
`else
      // burst: queue 0 with six words, queue 1 with one word
      reset = 1'b0;
      clear_q();
      fifo_error = 4'b0000;
      dest_almost_full = 1'b0;
      for (int j = 0; j < 6; j++) src_q[0].push_back(8'(8'hC0 + j));
      src_q[1].push_back(8'hD1);
      tick();
      reset = 1'b1;
      n = 0;
      for (int c = 0; c < 60 && n < 7; c++) begin
         tick();
         if (read != 4'b0000) begin
            got[n] = idx_of(read);
            n++;
         end
      end
      chk("burst_len", 32'(n), 32'd7);
      chk("burst_g0", 32'(got[0]), 32'd0);
      chk("burst_g1", 32'(got[1]), 32'd0);
      chk("burst_g2", 32'(got[2]), 32'd0);
      chk("burst_g3", 32'(got[3]), 32'd0);
      chk("burst_g4", 32'(got[4]), 32'd1);
      chk("burst_g5", 32'(got[5]), 32'd0);
      chk("burst_g6", 32'(got[6]), 32'd0);
      tick();
      tick();
      chk("burst_count", 32'(word_count), 32'd7);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 8, SHALL set the word width of all data ports.
REQ-002 Parameter NUM_Q, default 4, SHALL be fixed at 4 source FIFO_6x8 queues; other values are unsupported.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 fifo_empty  input  4  per-queue empty flag; bit i belongs to queue i.
REQ-006 fifo_error  input  4  per-queue error flag; while set, that queue is masked from arbitration.
REQ-007 data_in_0..data_in_3  input  DATA_SIZE each  per-queue data_out_pop, valid the cycle after the matching read.
REQ-008 dest_almost_full  input  1  back-pressure from the destination FIFO.
REQ-009 read  output  4  one-hot pop strobe to the source queues.
REQ-010 dest_write  output  1  push strobe to the destination FIFO.
REQ-011 dest_data  output  DATA_SIZE  word pushed to the destination.
REQ-012 grant  output  2  index of the queue currently owning the datapath.
REQ-013 arb_busy  output  1  high in any state other than IDLE.
REQ-014 word_count  output  8  count of words pushed, wrapping 255->0.

Function
REQ-015 The FSM SHALL have states IDLE, POP and PUSH only.
REQ-016 A queue is eligible when fifo_empty[i]=0 and fifo_error[i]=0.
REQ-017 In IDLE, with dest_almost_full=0 and at least one queue eligible, the arbiter SHALL register grant = first eligible queue scanning from (last_grant+1) mod 4 upward, then enter POP.
REQ-018 In IDLE, with dest_almost_full=1 or no queue eligible, the FSM SHALL remain in IDLE with read=0 and dest_write=0.
REQ-019 In POP, read[grant] SHALL be 1 for exactly that one cycle, all other read bits 0; next state is PUSH unconditionally.
REQ-020 In PUSH, dest_write SHALL be 1 and dest_data SHALL equal data_in_<grant> (combinational mux on the registered grant); word_count increments at the end of the cycle.
REQ-021 Without burst (REQ-027), PUSH SHALL always return to IDLE and set last_grant = grant.
REQ-022 Latency from IDLE arbitration to dest_write SHALL be 2 cycles; steady-state throughput is 1 word per 3 cycles.
REQ-023 Outside PUSH, dest_write=0 and dest_data=0.
REQ-024 dest_almost_full rising during POP or PUSH SHALL NOT abort the transfer; it is honoured at the next IDLE.
REQ-025 fifo_error[grant] rising during POP or PUSH SHALL NOT abort the transfer; that queue is masked from the next arbitration.

Reset
REQ-026 While reset=0: state=IDLE, read=0, dest_write=0, dest_data=0, grant=0, last_grant=3 (so queue 0 wins first), arb_busy=0, word_count=0 and burst_cnt=0, all taking effect immediately and asynchronously, including mid-POP or mid-PUSH. The first arbitration SHALL occur on the first rising edge with reset=1.

Configuration
REQ-027 With macro ARB_BURST_EN defined, PUSH SHALL go directly to POP on the same grant when the granted queue is still eligible, dest_almost_full=0 and burst_cnt<3, giving up to 4 back-to-back words per grant at 1 word per 2 cycles. burst_cnt SHALL reset to 0 on every new IDLE arbitration. Without ARB_BURST_EN, burst_cnt does not exist and REQ-021 applies.

Verification
REQ-028 Reset released with queues 1 and 3 non-empty -> read=4'b0010 in cycle 2 and dest_write in cycle 3 carrying data_in_1, then read=4'b1000.
REQ-029 All four queues non-empty, 8 transfers -> grant sequence 0,1,2,3,0,1,2,3 and word_count=8.
REQ-030 dest_almost_full=1 held 10 cycles with queues non-empty -> no read and no dest_write during the hold; arbitration resumes the cycle after release.
REQ-031 fifo_error=4'b0100 with all queues non-empty -> queue 2 is never granted; sequence is 0,1,3,0,...
REQ-032 reset driven to 0 during POP -> read drops to 0 at once, no dest_write follows, and word_count=0.
REQ-033 ARB_BURST_EN defined, queue 0 holding 6 words and queue 1 holding 1 word -> grants 0,0,0,0,1,0,0.
